weight_fetch_ctrl: RTL and testbench

Read initiator for the synchronous weight ROM (one 128-bit word per read, split into four 32-bit lanes). On `start`, it walks filter × channel-group × kernel-row reads from a base address and issues `read_enable`/`addr` to the ROM. It absorbs the ROM's one-cycle read latency and presents each word to the systolic-array weight loader through a valid/ready stream. Backpressure never drops or duplicates a word.

---
 rtl/weight_fetch_ctrl.sv | 162 ++++++++++++++++
 tb/tb_weight_fetch_ctrl.sv | 211 +++++++++++++++++++++
 2 files changed

// File: rtl/weight_fetch_ctrl.sv
// weight_fetch_ctrl: walks filter x group x row reads of the weight ROM,
// hides the ROM's one-cycle latency and streams 128-bit words through a
// 2-entry valid/ready FIFO with row/group/filter/last tags.
// Optional macro: WEIGHT_FETCH_BOUNDS_CHECK_EN enables the end-address check
// and the sticky err flag; otherwise err is 0 and addresses wrap.
module weight_fetch_ctrl #(
  parameter int DEPTH  = 2696,
  parameter int ADDR_W = $clog2(DEPTH)
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              start,
  input  logic [ADDR_W-1:0] base_addr,
  input  logic [2:0]        num_rows,
  input  logic [7:0]        num_groups,
  input  logic [7:0]        num_filters,
  output logic              rom_read_enable,
  output logic [ADDR_W-1:0] rom_addr,
  input  logic [31:0]       rom_data0,
  input  logic [31:0]       rom_data1,
  input  logic [31:0]       rom_data2,
  input  logic [31:0]       rom_data3,
  output logic              w_valid,
  input  logic              w_ready,
  output logic [31:0]       w_data0,
  output logic [31:0]       w_data1,
  output logic [31:0]       w_data2,
  output logic [31:0]       w_data3,
  output logic [2:0]        w_row,
  output logic [7:0]        w_group,
  output logic [7:0]        w_filter,
  output logic              w_last,
  output logic              busy,
  output logic              done,
  output logic              err
);
  typedef enum logic [1:0] {IDLE, ISSUE, DRAIN, DONE} state_t;

  typedef struct packed {
    logic [2:0] row;
    logic [7:0] group;
    logic [7:0] filter;
    logic       last;
  } tag_t;

  typedef struct packed {
    logic [3:0][31:0] data;
    tag_t             tag;
  } entry_t;

  state_t            state;
  logic [ADDR_W-1:0] base_q, idx, addr_hold;
  logic [2:0]        rows_q, row_c;
  logic [7:0]        groups_q, filters_q, grp_c, fil_c;
  logic              busy_q, done_q, err_q;

  logic              pend_vld;
  tag_t              pend_tag;
  entry_t            mem [2];
  logic              rd_ptr, wr_ptr;
  logic [1:0]        count;

  logic              pop, issue, last_rd, zero_dim, oob;
  logic [2:0]        used;
  logic [3:0][31:0]  rom_lanes;
  entry_t            head;

  assign rom_lanes = {rom_data3, rom_data2, rom_data1, rom_data0};
  assign head      = mem[rd_ptr];
  assign w_valid   = (count != 2'd0);
  assign pop       = w_valid && w_ready;
  // words buffered plus the one possibly still inside the ROM
  assign used      = {1'b0, count} + {2'b0, pend_vld};
  assign issue     = (state == ISSUE) && ((used - {2'b0, pop}) < 3'd2);
  assign last_rd   = (row_c == rows_q - 3'd1) && (grp_c == groups_q - 8'd1) &&
                     (fil_c == filters_q - 8'd1);
  assign zero_dim  = (num_rows == 3'd0) || (num_groups == 8'd0) || (num_filters == 8'd0);

`ifdef WEIGHT_FETCH_BOUNDS_CHECK_EN
  logic [19:0] end_addr;
  assign end_addr = 20'(base_addr) + 20'(num_rows) * 20'(num_groups) * 20'(num_filters) - 20'd1;
  assign oob      = (end_addr >= 20'(DEPTH));
  assign err      = err_q;
`else
  assign oob      = 1'b0;
  assign err      = 1'b0;
`endif

  assign rom_read_enable = issue;
  assign rom_addr        = issue ? (base_q + idx) : addr_hold;
  assign w_data0  = head.data[0];
  assign w_data1  = head.data[1];
  assign w_data2  = head.data[2];
  assign w_data3  = head.data[3];
  assign w_row    = head.tag.row;
  assign w_group  = head.tag.group;
  assign w_filter = head.tag.filter;
  assign w_last   = head.tag.last;
  assign busy     = busy_q;
  assign done     = done_q;

  // control FSM: job sampling, read walk counters, busy/done/err
  always_ff @(posedge clk) begin
    if (reset) begin
      state <= IDLE; base_q <= '0; idx <= '0; addr_hold <= '0;
      rows_q <= '0; groups_q <= '0; filters_q <= '0;
      row_c <= '0; grp_c <= '0; fil_c <= '0;
      busy_q <= 1'b0; done_q <= 1'b0; err_q <= 1'b0;
    end else begin
      if (issue) addr_hold <= rom_addr;
      case (state)
        IDLE: if (start) begin
          base_q <= base_addr; rows_q <= num_rows;
          groups_q <= num_groups; filters_q <= num_filters;
          idx <= '0; row_c <= '0; grp_c <= '0; fil_c <= '0;
          err_q <= !zero_dim && oob;
          if (zero_dim || oob) begin
            state <= DONE; done_q <= 1'b1;
          end else begin
            state <= ISSUE; busy_q <= 1'b1;
          end
        end
        ISSUE: if (issue) begin
          idx <= idx + 1'b1;
          if (row_c == rows_q - 3'd1) begin
            row_c <= '0;
            if (grp_c == groups_q - 8'd1) begin
              grp_c <= '0;
              fil_c <= fil_c + 8'd1;
            end else grp_c <= grp_c + 8'd1;
          end else row_c <= row_c + 3'd1;
          if (last_rd) state <= DRAIN;
        end
        DRAIN: if (pop && head.tag.last) begin
          state <= DONE; busy_q <= 1'b0; done_q <= 1'b1;
        end
        DONE: begin
          state <= IDLE; done_q <= 1'b0;
        end
        default: state <= IDLE;
      endcase
    end
  end

  // tag pipeline matching ROM latency, and the 2-entry output FIFO
  always_ff @(posedge clk) begin
    if (reset) begin
      pend_vld <= 1'b0; pend_tag <= '0;
      mem[0] <= '0; mem[1] <= '0;
      rd_ptr <= 1'b0; wr_ptr <= 1'b0; count <= '0;
    end else begin
      pend_vld <= issue;
      if (issue) pend_tag <= '{row: row_c, group: grp_c, filter: fil_c, last: last_rd};
      if (pend_vld) begin
        mem[wr_ptr] <= '{data: rom_lanes, tag: pend_tag};
        wr_ptr      <= ~wr_ptr;
      end
      if (pop) rd_ptr <= ~rd_ptr;
      count <= count + {1'b0, pend_vld} - {1'b0, pop};
    end
  end
endmodule

// File: tb/tb_weight_fetch_ctrl.sv
// Bench for weight_fetch_ctrl: ROM model, queue-based expected stream,
// per-cycle compare process plus literal latency/count checks.
module tb_weight_fetch_ctrl;
  localparam int DEPTH  = 2696;
  localparam int ADDR_W = 12;

  logic clk = 0, reset = 1, start = 0, w_ready = 0;
  logic [ADDR_W-1:0] base_addr = '0, rom_addr;
  logic [2:0] num_rows = '0, w_row;
  logic [7:0] num_groups = '0, num_filters = '0, w_group, w_filter;
  logic rom_read_enable, w_valid, w_last, busy, done, err;
  logic [31:0] rom_data0 = '0, rom_data1 = '0, rom_data2 = '0, rom_data3 = '0;
  logic [31:0] w_data0, w_data1, w_data2, w_data3;

  weight_fetch_ctrl #(.DEPTH(DEPTH), .ADDR_W(ADDR_W)) dut (
    .clk(clk), .reset(reset), .start(start), .base_addr(base_addr),
    .num_rows(num_rows), .num_groups(num_groups), .num_filters(num_filters),
    .rom_read_enable(rom_read_enable), .rom_addr(rom_addr),
    .rom_data0(rom_data0), .rom_data1(rom_data1), .rom_data2(rom_data2), .rom_data3(rom_data3),
    .w_valid(w_valid), .w_ready(w_ready),
    .w_data0(w_data0), .w_data1(w_data1), .w_data2(w_data2), .w_data3(w_data3),
    .w_row(w_row), .w_group(w_group), .w_filter(w_filter), .w_last(w_last),
    .busy(busy), .done(done), .err(err));

  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  function automatic logic [31:0] lane(input logic [ADDR_W-1:0] a, input int k);
    return {4'(k), 8'h5A, 8'h00, a};
  endfunction

  // synchronous ROM: data valid the cycle after the strobe
  always @(posedge clk)
    if (rom_read_enable) begin
      rom_data0 <= lane(rom_addr, 0); rom_data1 <= lane(rom_addr, 1);
      rom_data2 <= lane(rom_addr, 2); rom_data3 <= lane(rom_addr, 3);
    end

  int checks = 0, errors = 0;
  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  typedef struct {
    logic [ADDR_W-1:0] addr;
    logic [2:0] row;
    logic [7:0] grp, fil;
    logic last;
  } exp_t;

  exp_t beat_q[$];
  logic [ADDR_W-1:0] addr_q[$];
  logic m_busy = 0, m_done_now = 0, m_done_next = 0, m_err = 0, prev_stall = 0, done_seen = 0;
  logic [ADDR_W-1:0] last_addr = '0, first_addr = '0;
  int issued = 0, popped = 0, t_start = 0, first_rd = -1, first_vld = -1, done_cyc = 0;
  int job_reads = 0, job_beats = 0;

  // model and per-cycle comparison
  always @(negedge clk) begin
    if (reset) begin
      beat_q.delete(); addr_q.delete();
      m_busy = 0; m_done_now = 0; m_done_next = 0; m_err = 0; prev_stall = 0;
      last_addr = '0; issued = 0; popped = 0;
    end else begin
      logic pop_now;
      pop_now = w_valid && w_ready;
      m_done_now = m_done_next; m_done_next = 0;
      chk("busy", busy, m_busy);
      chk("done", done, m_done_now);
      chk("err", err, m_err);
      if (done) begin done_cyc = cyc; done_seen = 1; end
      if (rom_read_enable) begin
        if (first_rd < 0) begin first_rd = cyc; first_addr = rom_addr; end
        job_reads++;
        checks++;
        if (addr_q.size() == 0) begin
          errors++; $display("FAIL unexpected_read: got addr %0d expected no read", rom_addr);
        end else begin
          last_addr = addr_q.pop_front();
          chk("rom_addr", rom_addr, last_addr);
        end
        chk("credit", 32'((issued - popped - int'(pop_now)) < 2), 1);
        issued++;
      end else chk("rom_addr_hold", rom_addr, last_addr);
      if (prev_stall) chk("stall_valid", w_valid, 1);
      if (w_valid) begin
        if (first_vld < 0) first_vld = cyc;
        checks++;
        if (beat_q.size() == 0) begin
          errors++; $display("FAIL unexpected_beat: got valid expected idle");
        end else begin
          exp_t e;
          e = beat_q[0];
          chk("w_data0", w_data0, lane(e.addr, 0)); chk("w_data1", w_data1, lane(e.addr, 1));
          chk("w_data2", w_data2, lane(e.addr, 2)); chk("w_data3", w_data3, lane(e.addr, 3));
          chk("w_row", w_row, e.row); chk("w_group", w_group, e.grp);
          chk("w_filter", w_filter, e.fil); chk("w_last", w_last, e.last);
          if (pop_now) begin
            void'(beat_q.pop_front());
            popped++; job_beats++;
            if (e.last) begin m_busy = 0; m_done_next = 1; end
          end
        end
      end
      prev_stall = w_valid && !w_ready;
      if (start && !m_busy && !m_done_now) begin
        int total, n;
        logic [19:0] end_a;
        t_start = cyc; first_rd = -1; first_vld = -1; job_reads = 0; job_beats = 0;
        m_err = 0;
        total = int'(num_rows) * int'(num_groups) * int'(num_filters);
        end_a = 20'(int'(base_addr) + total - 1);
        if (total == 0) m_done_next = 1;
`ifdef WEIGHT_FETCH_BOUNDS_CHECK_EN
        else if (end_a >= 20'(DEPTH)) begin m_err = 1; m_done_next = 1; end
`endif
        else begin
          n = 0;
          for (int f = 0; f < int'(num_filters); f++)
            for (int g = 0; g < int'(num_groups); g++)
              for (int r = 0; r < int'(num_rows); r++) begin
                logic [ADDR_W-1:0] a;
                a = base_addr + ADDR_W'(n);
                addr_q.push_back(a);
                beat_q.push_back('{a, 3'(r), 8'(g), 8'(f), n == total - 1});
                n++;
              end
          m_busy = 1;
        end
      end
    end
  end

  task automatic tick(); @(posedge clk); #1; endtask

  task automatic start_job(input int b, input int r, input int g, input int f);
    done_seen = 0;
    base_addr = ADDR_W'(b); num_rows = 3'(r); num_groups = 8'(g); num_filters = 8'(f);
    start = 1; tick(); start = 0;
  endtask

  task automatic wait_done();
    int n;
    n = 0;
    while (!done_seen && n < 300) begin tick(); n++; end
    chk("done_timeout", 32'(done_seen), 1);
    tick();
  endtask

  initial begin
    repeat (3) tick();
    chk("rst_valid", w_valid, 0); chk("rst_busy", busy, 0); chk("rst_done", done, 0);
    chk("rst_re", rom_read_enable, 0); chk("rst_addr", rom_addr, 0); chk("rst_data0", w_data0, 0);
    reset = 0; tick();

    // basic 3x1x1 at 10
    w_ready = 1;
    start_job(10, 3, 1, 1); wait_done();
    chk("basic_reads", job_reads, 3); chk("basic_beats", job_beats, 3);
    chk("basic_first_rd", first_rd - t_start, 1); chk("basic_first_addr", first_addr, 10);
    chk("basic_first_vld", first_vld - t_start, 3); chk("basic_done", done_cyc - t_start, 6);

    // zero dimension
    start_job(100, 2, 0, 3); wait_done();
    chk("zero_reads", job_reads, 0); chk("zero_done", done_cyc - t_start, 1);
    chk("zero_err", err, 0);

    // backpressure 2x2x2
    start_job(200, 2, 2, 2);
    for (int i = 0; i < 8; i++) begin w_ready = (i % 2 == 0); tick(); end
    w_ready = 0; repeat (5) tick();
    w_ready = 1; wait_done();
    chk("bp_beats", job_beats, 8); chk("bp_reads", job_reads, 8);

    // start while busy is ignored
    start_job(300, 2, 3, 1); tick();
    base_addr = 50; num_rows = 5; num_groups = 5; num_filters = 5; start = 1; tick(); start = 0;
    wait_done();
    chk("busy_start_beats", job_beats, 6); chk("busy_start_addr", first_addr, 300);

    // reset mid-job
    start_job(400, 4, 4, 1);
    for (int n = 0; n < 100 && job_beats < 3; n++) tick();
    chk("mid_beats_seen", 32'(job_beats >= 3), 1);
    reset = 1; tick();
    chk("mrst_valid", w_valid, 0); chk("mrst_busy", busy, 0); chk("mrst_re", rom_read_enable, 0);
    chk("mrst_addr", rom_addr, 0); chk("mrst_data", w_data2, 0); chk("mrst_last", w_last, 0);
    reset = 0; repeat (4) tick();
    start_job(500, 2, 1, 2); wait_done();
    chk("after_rst_beats", job_beats, 4); chk("after_rst_addr", first_addr, 500);

`ifdef WEIGHT_FETCH_BOUNDS_CHECK_EN
    start_job(2690, 7, 1, 1); wait_done();
    chk("oob_err", err, 1); chk("oob_reads", job_reads, 0);
    start_job(2689, 7, 1, 1); wait_done();
    chk("inb_err", err, 0); chk("inb_reads", job_reads, 7);
`else
    start_job(4094, 2, 1, 2); wait_done();
    chk("wrap_beats", job_beats, 4); chk("wrap_err", err, 0);
`endif

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
